lifo_stack_param: RTL and testbench
===================================

// Module: lifo_stack_param
// PURPOSE
//  Parametrised LIFO stack, next generation of the 8-bit LIFO: configurable width/depth,
//  simultaneous push+pop (replace-top), registered pop data with valid strobe,
//  combinational peek, occupancy count, almost-full threshold, sticky overflow/underflow flags.
//  Used as a generic stack buffer for datapath and control blocks (return stacks, undo buffers).
// PARAMETERS
//  DATA_W     8   width of each entry
//  DEPTH      8   number of entries, >= 2
//  AF_THRESH  6   almost_full asserts when count >= AF_THRESH, 1..DEPTH
// PORTS
//  clk          in   1                   clock, rising edge
//  rst          in   1                   asynchronous reset, active-high
//  wn           in   1                   push request
//  rn           in   1                   pop request
//  datain       in   DATA_W              push data
//  clr_err      in   1                   synchronous clear of ovf/unf
//  dataout      out  DATA_W              popped data, registered
//  rd_valid     out  1                   1-cycle pulse: dataout updated by accepted pop
//  top          out  DATA_W              combinational peek of top entry, 0 when empty
//  count        out  $clog2(DEPTH+1)     current occupancy, 0..DEPTH
//  full         out  1                   count == DEPTH
//  empty        out  1                   count == 0
//  almost_full  out  1                   count >= AF_THRESH
//  ovf          out  1                   sticky: push attempted while full
//  unf          out  1                   sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation): count=0, dataout=0, rd_valid=0, ovf=unf=0;
//   storage array not reset. full/empty/almost_full/top derived from count -> 0/1/0/0.
//  All state changes on rising clk; flags combinational from registered count.
//  wn=1,rn=0: !full -> mem[count]<=datain, count+1. full -> dropped, count/mem unchanged, ovf<=1.
//  wn=0,rn=1: !empty -> dataout<=mem[count-1], rd_valid<=1, count-1.
//   empty -> dataout holds, rd_valid<=0, unf<=1.
//  wn=1,rn=1: !empty -> dataout<=mem[count-1], mem[count-1]<=datain, rd_valid<=1, count unchanged
//   (also legal when full; no ovf). empty -> pass-through: dataout<=datain, rd_valid<=1,
//   count stays 0, no unf.
//  wn=0,rn=0: no change; rd_valid<=0; dataout holds last popped value.
//  Pop latency: 1 cycle (data valid with rd_valid in the cycle after the request edge).
//  top = mem[count-1] when count>0 else 0; reflects pushes the cycle after the edge.
//  clr_err=1 clears ovf/unf at the edge; a new error in the same cycle wins (flag stays 1).
//  count never wraps: saturates logically at 0 and DEPTH via the rules above.
// STRUCTURE
//  Shared include lifo_defs.vh: LIFO_CNT_W(depth) width macro, default DATA_W/DEPTH constants.
//  Sub-module lifo_ram: DEPTH x DATA_W array, one write port, one async read port (addr count-1);
//   top-level holds count, dataout reg, rd_valid, flags and push/pop decode.
//  Elaboration check: AF_THRESH in 1..DEPTH, DEPTH >= 2.
// TESTING (DATA_W=8, DEPTH=8, AF_THRESH=6)
//  1 Push 100,150,200,40,70,65,15 then 7 pops -> dataout 15,65,70,40,200,150,100 each with
//    rd_valid=1; final count=0, empty=1, top=0.
//  2 Push 8 values -> almost_full=1 at count 6, full=1 at 8; 9th push (99) -> ovf=1, count=8,
//    top unchanged; clr_err -> ovf=0; clr_err with concurrent full push -> ovf stays 1.
//  3 Pop when empty after prior pop of 100 -> unf=1, rd_valid=0, dataout stays 100.
//  4 Push 10,20; wn=rn=1 datain=30 -> dataout=20, count=2, top=30; then pop -> 30, pop -> 10.
//  5 Empty, wn=rn=1 datain=55 -> dataout=55, rd_valid=1, count=0, unf=0; full, wn=rn=1 -> no ovf.
//  6 Push 3 values, assert rst between clock edges -> count=0, empty=1, dataout=0, flags 0
//    immediately; subsequent push 77/pop -> 77.

Source files
------------

// File: rtl/lifo_stack_param_pkg.sv
// Shared definitions for the parametrised LIFO stack: default geometry,
// occupancy-counter width helper and the push/pop request decode type.
package lifo_stack_param_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // Request decode: {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } lifo_op_e;

    // Width of a counter able to hold 0..depth inclusive
    function automatic int lifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_stack_param_ram.sv
// Storage array for the LIFO: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module lifo_stack_param_ram
    import lifo_stack_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the selected entry when the controller enables it
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack: push/pop/replace-top, registered pop data with a
// valid strobe, combinational peek, occupancy and sticky error flags.
module lifo_stack_param
    import lifo_stack_param_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wn,
    input  logic                             rn,
    input  logic [DATA_W-1:0]                datain,
    input  logic                             clr_err,
    output logic [DATA_W-1:0]                dataout,
    output logic                             rd_valid,
    output logic [DATA_W-1:0]                top,
    output logic [lifo_cnt_w(DEPTH)-1:0]     count,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             ovf,
    output logic                             unf
);

    localparam int CW = lifo_cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    // Reject geometries the counter/flag logic is not built for
    if (DEPTH < 2) begin : g_bad_depth
        $error("lifo_stack_param: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("lifo_stack_param: AF_THRESH must be in 1..DEPTH");
    end

    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [CW-1:0]     cnt_m1_s;
    logic              full_s, empty_s;
    logic              we_s;
    logic [AW-1:0]     waddr_s;
    logic [AW-1:0]     raddr_s;
    logic [DATA_W-1:0] rdata_s;
    lifo_op_e          op_s;

    assign op_s     = lifo_op_e'({wn, rn});
    assign cnt_m1_s = count_q - CW'(1);
    assign raddr_s  = cnt_m1_s[AW-1:0];
    assign full_s   = (count_q == CW'(DEPTH));
    assign empty_s  = (count_q == CW'(0));

    lifo_stack_param_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (datain),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Decode the request against occupancy into next state and RAM write
    always_comb begin
        count_d    = count_q;
        dataout_d  = dataout_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q & ~clr_err;
        unf_d      = unf_q & ~clr_err;
        we_s       = 1'b0;
        waddr_s    = count_q[AW-1:0];
        case (op_s)
            OP_PUSH: begin
                if (!full_s) begin
                    we_s    = 1'b1;
                    waddr_s = count_q[AW-1:0];
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty_s) begin
                    dataout_d  = rdata_s;
                    rd_valid_d = 1'b1;
                    count_d    = cnt_m1_s;
                end else begin
                    unf_d = 1'b1;
                end
            end
            OP_REPL: begin
                // Replace-top keeps occupancy, so it is legal even when full;
                // on an empty stack the push data passes straight through.
                if (!empty_s) begin
                    dataout_d  = rdata_s;
                    rd_valid_d = 1'b1;
                    we_s       = 1'b1;
                    waddr_s    = raddr_s;
                end else begin
                    dataout_d  = datain;
                    rd_valid_d = 1'b1;
                end
            end
            OP_IDLE: begin
                rd_valid_d = 1'b0;
            end
            default: begin
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // Control and output registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= CW'(0);
            dataout_q  <= DATA_W'(0);
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            dataout_q  <= dataout_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign dataout     = dataout_q;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign full        = full_s;
    assign empty       = empty_s;
    assign almost_full = (count_q >= CW'(AF_THRESH));
    assign ovf         = ovf_q;
    assign unf         = unf_q;
    assign top         = empty_s ? DATA_W'(0) : rdata_s;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed testbench for lifo_stack_param (DATA_W=8, DEPTH=8, AF_THRESH=6).
module tb_lifo_stack_param;

    logic       clk;
    logic       rst;
    logic       wn;
    logic       rn;
    logic [7:0] datain;
    logic       clr_err;
    logic [7:0] dataout;
    logic       rd_valid;
    logic [7:0] top;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       ovf;
    logic       unf;

    int tests_run = 0;
    int tests_failed = 0;

    lifo_stack_param #(
        .DATA_W    (8),
        .DEPTH     (8),
        .AF_THRESH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wn          (wn),
        .rn          (rn),
        .datain      (datain),
        .clr_err     (clr_err),
        .dataout     (dataout),
        .rd_valid    (rd_valid),
        .top         (top),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .ovf         (ovf),
        .unf         (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wn = 1'b0; rn = 1'b0; clr_err = 1'b0; datain = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic push(input logic [7:0] v);
        wn = 1'b1; rn = 1'b0; datain = v;
        tick();
        wn = 1'b0;
    endtask

    task automatic pop();
        wn = 1'b0; rn = 1'b1;
        tick();
        rn = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
            top !== 8'd0 || dataout !== 8'd0 || rd_valid !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b af=%b top=%0d dout=%0d rv=%b ovf=%b unf=%b, required 0 1 0 0 0 0 0 0 0",
                     count, empty, full, almost_full, top, dataout, rd_valid, ovf, unf);
        end
    endtask

    task automatic test_push_pop_order();
        logic [7:0] vals [7];
        vals = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};
        do_reset();
        for (int i = 0; i < 7; i++) push(vals[i]);
        tests_run++;
        if (count !== 4'd7 || top !== 8'd15) begin
            tests_failed++;
            $display("FAIL fill7: count=%0d top=%0d, required 7 15", count, top);
        end
        for (int i = 6; i >= 0; i--) begin
            pop();
            tests_run++;
            if (dataout !== vals[i] || rd_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL pop_order[%0d]: dataout=%0d rd_valid=%b, required %0d 1", i, dataout, rd_valid, vals[i]);
            end
        end
        tests_run++;
        if (count !== 4'd0 || empty !== 1'b1 || top !== 8'd0) begin
            tests_failed++;
            $display("FAIL drained: count=%0d empty=%b top=%0d, required 0 1 0", count, empty, top);
        end
        tick();
        tests_run++;
        if (rd_valid !== 1'b0 || dataout !== 8'd100) begin
            tests_failed++;
            $display("FAIL idle_hold: rd_valid=%b dataout=%0d, required 0 100", rd_valid, dataout);
        end
    endtask

    task automatic test_full_ovf();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            push(8'(i * 11));
            tests_run++;
            if (almost_full !== (i >= 6) || full !== (i == 8) || count !== 4'(i)) begin
                tests_failed++;
                $display("FAIL fill_flags[%0d]: af=%b full=%b count=%0d, required %b %b %0d",
                         i, almost_full, full, count, (i >= 6), (i == 8), i);
            end
        end
        push(8'd99);
        tests_run++;
        if (ovf !== 1'b1 || count !== 4'd8 || top !== 8'd88) begin
            tests_failed++;
            $display("FAIL overflow: ovf=%b count=%0d top=%0d, required 1 8 88", ovf, count, top);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_ovf: ovf=%b, required 0", ovf);
        end
        clr_err = 1'b1;
        push(8'd99);
        clr_err = 1'b0;
        tests_run++;
        if (ovf !== 1'b1 || count !== 4'd8) begin
            tests_failed++;
            $display("FAIL clr_vs_ovf: ovf=%b count=%0d, required 1 8", ovf, count);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        push(8'd100);
        pop();
        pop();
        tests_run++;
        if (unf !== 1'b1 || rd_valid !== 1'b0 || dataout !== 8'd100 || count !== 4'd0) begin
            tests_failed++;
            $display("FAIL underflow: unf=%b rd_valid=%b dataout=%0d count=%0d, required 1 0 100 0",
                     unf, rd_valid, dataout, count);
        end
    endtask

    task automatic test_replace_top();
        do_reset();
        push(8'd10);
        push(8'd20);
        wn = 1'b1; rn = 1'b1; datain = 8'd30;
        tick();
        wn = 1'b0; rn = 1'b0;
        tests_run++;
        if (dataout !== 8'd20 || rd_valid !== 1'b1 || count !== 4'd2 || top !== 8'd30) begin
            tests_failed++;
            $display("FAIL replace: dataout=%0d rd_valid=%b count=%0d top=%0d, required 20 1 2 30",
                     dataout, rd_valid, count, top);
        end
        pop();
        tests_run++;
        if (dataout !== 8'd30) begin
            tests_failed++;
            $display("FAIL replace_pop1: dataout=%0d, required 30", dataout);
        end
        pop();
        tests_run++;
        if (dataout !== 8'd10 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL replace_pop2: dataout=%0d empty=%b, required 10 1", dataout, empty);
        end
    endtask

    task automatic test_passthrough_and_full_replace();
        do_reset();
        wn = 1'b1; rn = 1'b1; datain = 8'd55;
        tick();
        wn = 1'b0; rn = 1'b0;
        tests_run++;
        if (dataout !== 8'd55 || rd_valid !== 1'b1 || count !== 4'd0 || unf !== 1'b0 || top !== 8'd0) begin
            tests_failed++;
            $display("FAIL passthrough: dataout=%0d rd_valid=%b count=%0d unf=%b top=%0d, required 55 1 0 0 0",
                     dataout, rd_valid, count, unf, top);
        end
        for (int i = 1; i <= 8; i++) push(8'(i));
        wn = 1'b1; rn = 1'b1; datain = 8'd200;
        tick();
        wn = 1'b0; rn = 1'b0;
        tests_run++;
        if (ovf !== 1'b0 || count !== 4'd8 || dataout !== 8'd8 || top !== 8'd200 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_replace: ovf=%b count=%0d dataout=%0d top=%0d rd_valid=%b, required 0 8 8 200 1",
                     ovf, count, dataout, top, rd_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(8'd1);
        push(8'd2);
        push(8'd3);
        pop();
        pop();
        pop();
        pop();
        push(8'd4);
        // now dataout=1, unf=1, count=1
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (count !== 4'd0 || empty !== 1'b1 || dataout !== 8'd0 || ovf !== 1'b0 || unf !== 1'b0 ||
            rd_valid !== 1'b0 || top !== 8'd0) begin
            tests_failed++;
            $display("FAIL async_reset: count=%0d empty=%b dataout=%0d ovf=%b unf=%b rv=%b top=%0d, required 0 1 0 0 0 0 0",
                     count, empty, dataout, ovf, unf, rd_valid, top);
        end
        @(negedge clk);
        rst = 1'b0;
        push(8'd77);
        pop();
        tests_run++;
        if (dataout !== 8'd77 || rd_valid !== 1'b1 || count !== 4'd0) begin
            tests_failed++;
            $display("FAIL post_reset: dataout=%0d rd_valid=%b count=%0d, required 77 1 0", dataout, rd_valid, count);
        end
    endtask

    initial begin
        rst = 1'b1; wn = 1'b0; rn = 1'b0; clr_err = 1'b0; datain = 8'd0;
        test_reset();
        test_push_pop_order();
        test_full_ovf();
        test_underflow();
        test_replace_top();
        test_passthrough_and_full_replace();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
